serial_subtractor32: RTL
========================

Name: serial_subtractor32

Overview:
- Digit-serial two's-complement subtractor: result = a - b - borrow_i, one DIGIT-wide slice per clock, LSB slice first.
- Companion to the 32-bit ripple adder: same operand widths, but in the subtract direction and with a valid/ready handshake on both sides.
- Sits in the datapath where area matters more than latency.
- Produces the difference, the borrow-out and the flags zero, negative and signed overflow.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge
- rstn_i  in  1  asynchronous active-low reset
- in_valid_i  in  1  operands valid
- in_ready_o  out  1  block can accept operands
- a_i  in  WIDTH  minuend
- b_i  in  WIDTH  subtrahend
- borrow_i  in  1  borrow-in
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- diff_o  out  WIDTH  a - b - borrow_i, modulo 2^WIDTH
- borrow_o  out  1  1 when the unsigned value a < b + borrow_i
- zero_o  out  1  diff_o == 0
- neg_o  out  1  diff_o[WIDTH-1]
- ovf_o  out  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])

Behaviour:
- Reset, asynchronous, active low, is the only clock and reset arrangement:
  - state = IDLE; counter = 0.
  - Operand, result and borrow registers = 0.
  - in_ready_o = 1; out_valid_o = 0; diff_o = 0; borrow_o = 0; zero_o = 0; neg_o = 0; ovf_o = 0.
- Arithmetic per slice k:
  - {c, d} = a[k] + ~b[k] + c_prev, with c_prev = ~borrow_i for slice 0.
  - After the last slice, borrow_o = ~c.
  - All arithmetic is modulo 2^WIDTH.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready_o = 1. When in_valid_i is high on an edge: latch a_i, b_i and borrow_i, set counter = 0, go to BUSY. Otherwise stay.
  - BUSY: in_ready_o = 0. Each cycle, compute slice[counter], write it into diff_reg[counter*DIGIT +: DIGIT], register the carry, and counter++. At counter == WIDTH/DIGIT-1: write the last slice, register borrow_o and the flags, go to DONE.
  - DONE: out_valid_o = 1 and all outputs stable. When out_ready_i is high on an edge, go to IDLE; out_valid_o drops and in_ready_o rises on the next cycle.
- Latency:
  - Accept edge at T → out_valid_o high from T+8 (WIDTH/DIGIT = 8 BUSY cycles).
  - Minimum initiation interval = 10 cycles.
- Inputs outside IDLE: in_valid_i and the operand inputs are ignored in BUSY and DONE; the latched operands are used exclusively.
- Output stability: diff_o and the flags hold their values after leaving DONE until the next result completes. Consumers qualify them with out_valid_o.
- Zero-cycle handshake: out_ready_i may already be high when DONE is entered; the result is then consumed at the first DONE edge.
- Reset mid-BUSY or mid-DONE: immediate return to the reset state; the partial result is discarded and out_valid_o never pulses.
- Corner operand cases:
  - a == b with borrow_i = 0 → diff 0, zero_o = 1, borrow_o = 0.
  - a = 0, b = 0, borrow_i = 1 → all ones, borrow_o = 1.

Decomposition:
- Package serial_sub_pkg holds:
  - state enum state_e {IDLE, BUSY, DONE};
  - localparam NSLICE = WIDTH/DIGIT;
  - the counter width $clog2(NSLICE).
- Sub-module subtractor_slice: combinational DIGIT-bit slice with ports a, b, carry_in → diff, carry_out, implemented as a + ~b + cin.
- Top level holds the FSM, counter, operand/result registers and flag logic.
- Static check: elaboration error if WIDTH % DIGIT != 0.

Test Plan:
- 5 - 3, borrow_i = 0 → diff 0x00000002, borrow_o 0, zero 0, neg 0, ovf 0; out_valid_o exactly 8 cycles after accept.
- 3 - 5 → diff 0xFFFFFFFE, borrow_o 1, neg 1, ovf 0.
- 0x80000000 - 1 → diff 0x7FFFFFFF, ovf 1, borrow_o 0. Also 0x7FFFFFFF - 0xFFFFFFFF → 0x80000000, ovf 1, borrow_o 1.
- 0 - 0 with borrow_i = 1 → 0xFFFFFFFF, borrow_o 1. Then 0x1234 - 0x1234 → diff 0, zero 1.
- Backpressure: hold out_ready_i = 0 for 5 cycles → outputs stable and in_ready_o = 0 throughout. Toggle a_i and in_valid_i during BUSY → result unaffected. Release out_ready_i → in_ready_o high the next cycle.
- Assert rstn_i low at BUSY cycle 4 → all outputs return to reset values immediately. Then a new request, 10 - 4 → diff 6 with no residue from the aborted operation.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Default geometry is a 32-bit datapath processed four bits per cycle.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SUB_WIDTH = 32;
    localparam int SUB_DIGIT = 4;
    localparam int NSLICE    = SUB_WIDTH / SUB_DIGIT;

    // Counter width, never below one bit so a single-slice build still elaborates
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(NSLICE);

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/subtractor_slice.sv
// One DIGIT-wide subtract slice: a + ~b + carry_in, where carry is "no borrow".
module subtractor_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             carry_in,
    output logic [DIGIT-1:0] diff,
    output logic             carry_out
);

    assign {carry_out, diff} = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, carry_in};

endmodule

// File: rtl/serial_subtractor32.sv
// Digit-serial two's-complement subtractor with valid/ready on both sides.
// Computes a - b - borrow_i one slice per cycle, LSB slice first.
module serial_subtractor32
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int DIGIT = SUB_DIGIT
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             ovf_o
);

    localparam int SLICES = WIDTH / DIGIT;
    localparam int CW     = cnt_width(SLICES);
    localparam logic [CW-1:0] LAST_CNT = CW'(SLICES - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_geometry
        $error("serial_subtractor32: WIDTH must be a multiple of DIGIT");
    end

    state_e             state_r, next_state_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   a_r, b_r, work_r, diff_r, full_s;
    logic               carry_r;
    logic               borrow_r, zero_r, neg_r, ovf_r;
    logic               in_ready_r, out_valid_r;
    logic               in_ready_nx_s, out_valid_nx_s;
    logic [DIGIT-1:0]   slice_a_s, slice_b_s, slice_d_s;
    logic               slice_c_s;

    assign slice_a_s = a_r[cnt_r*DIGIT +: DIGIT];
    assign slice_b_s = b_r[cnt_r*DIGIT +: DIGIT];

    subtractor_slice #(.DIGIT(DIGIT)) u_slice (
        .a         (slice_a_s),
        .b         (slice_b_s),
        .carry_in  (carry_r),
        .diff      (slice_d_s),
        .carry_out (slice_c_s)
    );

    // Working result with the current slice merged in; final value on the last slice
    always_comb begin
        full_s = work_r;
        full_s[cnt_r*DIGIT +: DIGIT] = slice_d_s;
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid_i) next_state_s = BUSY;
                else            next_state_s = IDLE;
            end
            BUSY: begin
                if (cnt_r == LAST_CNT) next_state_s = DONE;
                else                   next_state_s = BUSY;
            end
            DONE: begin
                if (out_ready_i) next_state_s = IDLE;
                else             next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they can be registered
    always_comb begin
        in_ready_nx_s  = 1'b0;
        out_valid_nx_s = 1'b0;
        case (next_state_s)
            IDLE:    in_ready_nx_s  = 1'b1;
            BUSY:    in_ready_nx_s  = 1'b0;
            DONE:    out_valid_nx_s = 1'b1;
            default: in_ready_nx_s  = 1'b0;
        endcase
    end

    // Registered handshake outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
        end
    end

    // Operand capture, slice iteration and result/flag registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_r    <= {CW{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            work_r   <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            zero_r   <= 1'b0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid_i) begin
                        a_r     <= a_i;
                        b_r     <= b_i;
                        carry_r <= ~borrow_i;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                BUSY: begin
                    work_r  <= full_s;
                    carry_r <= slice_c_s;
                    if (cnt_r == LAST_CNT) begin
                        // Published outputs only change here, so they hold between results
                        cnt_r    <= {CW{1'b0}};
                        diff_r   <= full_s;
                        borrow_r <= ~slice_c_s;
                        zero_r   <= (full_s == {WIDTH{1'b0}});
                        neg_r    <= full_s[WIDTH-1];
                        ovf_r    <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], full_s[WIDTH-1]);
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign diff_o      = diff_r;
    assign borrow_o    = borrow_r;
    assign zero_o      = zero_r;
    assign neg_o       = neg_r;
    assign ovf_o       = ovf_r;

endmodule
